keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Drives and scans the 4x4 matrix keypad and produces the 5-bit key-event code
//  consumed by the calculator control logic. It is the producing end of the
//  key-event interface.
//  Debounces presses and emits exactly one single-cycle event per physical press.
//  A held key never re-fires, so one held digit does not append repeatedly (top*10+d).
// PARAMETERS
//  SCAN_DIV        1000  clocks each column is driven low (dwell); must be >= 3
//  DEBOUNCE_SCANS  4     consecutive full scans needed to accept a press or a release (>= 1)
// PORTS
//  clock    in   1  system clock; single clock domain
//  reset    in   1  synchronous, active-high reset
//  rows     in   4  keypad rows, active-low (pulled up), asynchronous to clock
//  columns  out  4  keypad column drive, active-low one-hot
//  value    out  5  key event: {1'b1, col[1:0], row[1:0]} for one cycle; 5'b00000 otherwise
// BEHAVIOUR
//  Reset values
//  - columns=4'b1110, value=5'b00000, state=SCAN, all counters, candidate and scan flags cleared.
//  Row sampling
//  - rows pass through a 2-FF synchroniser.
//  - A row is pressed when its synchronised bit is 0.
//  Column scanning
//  - Column k (0..3) is held low for SCAN_DIV clocks, in the order 1110 -> 1101 -> 1011 -> 0111 -> 1110.
//  - The scan free-runs in every state.
//  - The synchronised rows are sampled on the last clock of each dwell only.
//  Per-scan result
//  - found = any pressed key during the scan.
//  - code = first pressed key in scan order: column 0..3, then row 0..3 within the column.
//  - Lower column and lower row win on multiple presses.
//  - End-of-scan (EOS) = last dwell clock of column 3. One full scan = 4*SCAN_DIV clocks.
//  FSM, evaluated at EOS only
//  - SCAN
//    - found: candidate=code, cnt=1, go DEBOUNCE.
//    - If DEBOUNCE_SCANS==1, accept immediately instead.
//  - DEBOUNCE
//    - found and code==candidate: cnt++. When cnt==DEBOUNCE_SCANS, accept.
//    - found and code!=candidate: candidate=code, cnt=1.
//    - !found: return to SCAN.
//  - Accept
//    - value={1'b1,candidate} on the clock after EOS for exactly one cycle.
//    - Then go HELD with rel=0.
//  - HELD
//    - !found: rel++. When rel==DEBOUNCE_SCANS, go SCAN.
//    - found (any key, including a different one): rel=0. No rollover events.
//  Output rules
//  - value is 5'b00000 in every cycle except the accept cycle.
//  - value is never 5'b1xxxx for two consecutive cycles.
//  Latency
//  - From a clean press stable before the first sampled dwell: the pulse comes 1 clock after the DEBOUNCE_SCANS-th EOS.
//  Counter widths
//  - The dwell counter is sized for SCAN_DIV-1.
//  - cnt and rel are sized for DEBOUNCE_SCANS and saturate; they never wrap.
//  Reset mid-operation
//  - Any partial debounce or HELD state is discarded.
//  - A key held through reset must be re-debounced from SCAN and then fires once.
// TESTING (bench: SCAN_DIV=4, DEBOUNCE_SCANS=3; keypad model pulls row r low while column c is low)
//  1 After reset: columns steps 1110,1101,1011,0111 every 4 clocks and repeats; value stays 0 with no key.
//  2 Hold key col1,row1 for 20 scans -> exactly one pulse value=5'b10101, 1 clock after the 3rd EOS.
//  3 Key col3,row2 present on alternate scans only (bounce) -> no pulse.
//    Then make it steady -> one pulse 5'b11110.
//  4 Press col0,row0; release for 3 scans; press again -> two pulses 5'b10000.
//    A release lasting only 2 scans between presses -> only one pulse.
//  5 Keys col0,row2 and col3,row0 held together -> single pulse 5'b10010.
//    Then release col0 while holding col3 -> no further pulse.
//  6 Assert reset during DEBOUNCE (cnt=2) with key held -> value=0 and columns=1110 next clock.
//    After release of reset, the pulse comes 1 clock after the 3rd subsequent EOS.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces the
// first pressed key over whole scans and emits one single-cycle event per press.
module keypad_scanner #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] columns,
  output logic [4:0] value
);

  localparam int unsigned DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       columns_q, columns_d;
  logic             found_q, found_d;
  logic [3:0]       code_q, code_d;
  state_e           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, rel_q, rel_d;
  logic [4:0]       value_q, value_d;

  logic       dwell_last, eos, hit, scan_found, accept;
  logic [1:0] row_idx;
  logic [3:0] pressed, scan_code, accept_code;

  assign columns = columns_q;
  assign value   = value_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= 4'hF;
      sync2_q   <= 4'hF;
      div_q     <= '0;
      col_q     <= 2'd0;
      columns_q <= 4'b1110;
      found_q   <= 1'b0;
      code_q    <= 4'd0;
      state_q   <= ST_SCAN;
      cand_q    <= 4'd0;
      cnt_q     <= '0;
      rel_q     <= '0;
      value_q   <= 5'b00000;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      div_q     <= div_d;
      col_q     <= col_d;
      columns_q <= columns_d;
      found_q   <= found_d;
      code_q    <= code_d;
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      rel_q     <= rel_d;
      value_q   <= value_d;
    end
  end

  always_comb begin
    sync1_d     = rows;
    sync2_d     = sync1_q;
    div_d       = div_q;
    col_d       = col_q;
    columns_d   = columns_q;
    found_d     = found_q;
    code_d      = code_q;
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    rel_d       = rel_q;
    value_d     = 5'b00000;
    accept      = 1'b0;
    accept_code = cand_q;

    dwell_last = (div_q == DIV_LAST);
    eos        = dwell_last && (col_q == 2'd3);
    pressed    = ~sync2_q;
    hit        = |pressed;

    // Lowest pressed row wins within a column.
    row_idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (pressed[r]) row_idx = 2'(r);
    end

    // Earlier columns already found take priority over the current one.
    scan_found = found_q | hit;
    scan_code  = found_q ? code_q : {col_q, row_idx};

    if (dwell_last) begin
      div_d     = '0;
      col_d     = col_q + 2'd1;
      columns_d = ~(4'b0001 << col_d);
      found_d   = scan_found;
      code_d    = scan_code;
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    if (eos) begin
      found_d = 1'b0;
      code_d  = 4'd0;
      case (state_q)
        ST_SCAN: begin
          if (scan_found) begin
            cand_d = scan_code;
            cnt_d  = CNT_ONE;
            if (CNT_MAX == CNT_ONE) begin
              accept      = 1'b1;
              accept_code = scan_code;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (!scan_found) begin
            state_d = ST_SCAN;
            cnt_d   = '0;
          end else if (scan_code == cand_q) begin
            if (cnt_q >= CNT_MAX - CNT_ONE) accept = 1'b1;
            else                            cnt_d  = cnt_q + CNT_ONE;
          end else begin
            cand_d = scan_code;
            cnt_d  = CNT_ONE;
          end
        end
        ST_HELD: begin
          if (scan_found) begin
            rel_d = '0;
          end else if (rel_q >= CNT_MAX - CNT_ONE) begin
            state_d = ST_SCAN;
            rel_d   = '0;
          end else begin
            rel_d = rel_q + CNT_ONE;
          end
        end
        default: state_d = ST_SCAN;
      endcase

      if (accept) begin
        value_d = {1'b1, accept_code};
        state_d = ST_HELD;
        cnt_d   = '0;
        rel_d   = '0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a scan-level press/release model is
// compared every cycle, plus literal checks on pulse count, code and latency.
module tb_keypad_scanner;

  localparam int SD        = 4;
  localparam int DS        = 3;
  localparam int SCAN_CLKS = 4 * SD;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] columns;
  logic [4:0] value;
  logic [15:0] keys;   // bit c*4+r = key at column c, row r

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clock   (clock),
    .reset   (reset),
    .rows    (rows),
    .columns (columns),
    .value   (value)
  );

  always #5 clock = ~clock;

  // Keypad: a pressed key shorts its row to its column while that column is low.
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !columns[c]) rows[r] = 1'b0;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scan-level model: a press is accepted after DS consecutive scans whose
  // first key is the same; afterwards it re-arms only after DS empty scans.
  int         cyc = 0;
  bit         model_valid = 1'b0;
  bit         held = 1'b0;
  int         streak = 0;
  int         empty_run = 0;
  logic [3:0] last_code = 4'd0;
  logic [3:0] exp_columns = 4'b1110;
  logic [4:0] exp_value = 5'd0;

  always @(posedge clock) begin
    logic [3:0] code;
    if (reset) begin
      cyc = 0; held = 1'b0; streak = 0; empty_run = 0;
      last_code = 4'd0; exp_value = 5'd0; model_valid = 1'b1;
    end else begin
      exp_value = 5'd0;
      if (cyc % SCAN_CLKS == SCAN_CLKS - 1) begin
        code = 4'd0;
        for (int i = 15; i >= 0; i--) if (keys[i]) code = 4'(i);
        if (held) begin
          if (keys == 16'd0) begin
            empty_run++;
            if (empty_run == DS) begin held = 1'b0; streak = 0; end
          end else begin
            empty_run = 0;
          end
        end else if (keys == 16'd0) begin
          streak = 0;
        end else begin
          if (streak != 0 && code == last_code) streak++;
          else begin streak = 1; last_code = code; end
          if (streak == DS) begin
            exp_value = {1'b1, code};
            held = 1'b1; empty_run = 0; streak = 0;
          end
        end
      end
      cyc++;
    end
    exp_columns = 4'hF ^ (4'b0001 << ((cyc / SD) % 4));
  end

  int         pulses = 0;
  int         last_cyc = 0;
  logic [4:0] last_val = 5'd0;
  logic       prev_v4 = 1'b0;

  always @(negedge clock) begin
    if (model_valid) begin
      check("columns", 32'(columns), 32'(exp_columns));
      check("value", 32'(value), 32'(exp_value));
      check("back_to_back", 32'(prev_v4 & value[4]), 32'd0);
      if (value[4]) begin
        pulses++;
        last_val = value;
        last_cyc = cyc;
      end
      prev_v4 = value[4];
    end
  end

  task automatic run_scans(input int n);
    repeat (n * SCAN_CLKS) @(posedge clock);
    #1;
  endtask

  int p0, c0;

  initial begin
    reset = 1'b1;
    keys  = 16'd0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // 1: idle column walk, no events
    check("t1_cols0", 32'(columns), 32'h0000000E);
    check("t1_val0", 32'(value), 32'd0);
    repeat (SD) @(posedge clock);
    #1 check("t1_cols1", 32'(columns), 32'h0000000D);
    repeat (SCAN_CLKS - SD) @(posedge clock);
    #1;
    run_scans(1);
    check("t1_nopulse", 32'(pulses), 32'd0);

    // 2: hold col1,row1 for 20 scans
    p0 = pulses; c0 = cyc;
    keys = 16'h0020;
    run_scans(20);
    check("t2_count", 32'(pulses - p0), 32'd1);
    check("t2_code", 32'(last_val), 32'h15);
    check("t2_lat", 32'(last_cyc - c0), 32'd48);
    keys = 16'd0;
    run_scans(4);

    // 3: bouncing col3,row2 then steady
    p0 = pulses;
    for (int i = 0; i < 6; i++) begin
      keys = (i % 2 == 0) ? 16'h4000 : 16'h0000;
      run_scans(1);
    end
    check("t3_bounce", 32'(pulses - p0), 32'd0);
    keys = 16'h4000;
    run_scans(5);
    check("t3_count", 32'(pulses - p0), 32'd1);
    check("t3_code", 32'(last_val), 32'h1E);
    keys = 16'd0;
    run_scans(4);

    // 4: full release between presses vs. a too-short release
    p0 = pulses;
    keys = 16'h0001; run_scans(4);
    keys = 16'h0000; run_scans(3);
    keys = 16'h0001; run_scans(4);
    check("t4_two", 32'(pulses - p0), 32'd2);
    check("t4_code", 32'(last_val), 32'h10);
    keys = 16'h0000; run_scans(4);
    p0 = pulses;
    keys = 16'h0001; run_scans(4);
    keys = 16'h0000; run_scans(2);
    keys = 16'h0001; run_scans(4);
    check("t4_one", 32'(pulses - p0), 32'd1);
    keys = 16'h0000; run_scans(4);

    // 5: two keys, lower column wins; releasing it emits nothing
    p0 = pulses;
    keys = 16'h1004; run_scans(4);
    check("t5_count", 32'(pulses - p0), 32'd1);
    check("t5_code", 32'(last_val), 32'h12);
    keys = 16'h1000; run_scans(5);
    check("t5_norollover", 32'(pulses - p0), 32'd1);
    keys = 16'h0000; run_scans(4);

    // 6: reset during debounce with the key held
    p0 = pulses;
    keys = 16'h0020;
    run_scans(2);
    repeat (5) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1;
    check("t6_rst_cols", 32'(columns), 32'h0000000E);
    check("t6_rst_val", 32'(value), 32'd0);
    reset = 1'b0;
    c0 = cyc;
    check("t6_nopulse", 32'(pulses - p0), 32'd0);
    run_scans(4);
    check("t6_count", 32'(pulses - p0), 32'd1);
    check("t6_code", 32'(last_val), 32'h15);
    check("t6_lat", 32'(last_cyc - c0), 32'd48);
    keys = 16'd0;
    run_scans(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
